// File: rtl/prm_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prm_scan_pkg
//  Purpose  : Shared types and default sizes for the PRM edge-mask scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package prm_scan_pkg;

    localparam int DEF_IN_W     = 15;
    localparam int DEF_NUM_EDGE = 8;
    localparam int DEF_NUM_CUBE = 64;
    localparam int DEF_EDGE_W   = $clog2(DEF_NUM_EDGE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic                  en;
        logic [DEF_EDGE_W-1:0] edge_idx;
        logic [DEF_IN_W-1:0]   care;
        logic [DEF_IN_W-1:0]   val;
    } cube_t;

endpackage
`default_nettype wire

// File: rtl/prm_cube_ram.sv
`default_nettype none
// ============================================================================
//  Module   : prm_cube_ram
//  Purpose  : Cube table: one synchronous write port, one combinational read.
//  Revision : 1.0 - initial release
// ============================================================================
module prm_cube_ram #(
    parameter int IN_W     = 15,
    parameter int EDGE_W   = 3,
    parameter int NUM_CUBE = 64,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wr_en,
    input  logic [EDGE_W-1:0] wr_edge,
    input  logic [IN_W-1:0]   wr_care,
    input  logic [IN_W-1:0]   wr_val,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rd_en,
    output logic [EDGE_W-1:0] rd_edge,
    output logic [IN_W-1:0]   rd_care,
    output logic [IN_W-1:0]   rd_val
);

    logic [NUM_CUBE-1:0] en_q;
    logic [EDGE_W-1:0]   edge_q [NUM_CUBE];
    logic [IN_W-1:0]     care_q [NUM_CUBE];
    logic [IN_W-1:0]     val_q  [NUM_CUBE];
    logic                wr_ok;

    // Addresses past the table depth are ignored when the depth is not a power of two.
    if ((1 << ADDR_W) > NUM_CUBE) begin : g_addr_guard
        assign wr_ok = we && (waddr < ADDR_W'(NUM_CUBE));
    end else begin : g_addr_full
        assign wr_ok = we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
        end else if (wr_ok) begin
            en_q[waddr] <= wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            edge_q[waddr] <= wr_edge;
            care_q[waddr] <= wr_care;
            val_q[waddr]  <= wr_val;
        end
    end

    assign rd_en   = en_q[raddr];
    assign rd_edge = edge_q[raddr];
    assign rd_care = care_q[raddr];
    assign rd_val  = val_q[raddr];

endmodule
`default_nettype wire

// File: rtl/prm_edge_mask_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : prm_edge_mask_scanner
//  Purpose  : Scans every voxel code against the cube table, accumulating
//             per-edge collision flags over a frame.
//  Revision : 1.0 - initial release
// ============================================================================
module prm_edge_mask_scanner
    import prm_scan_pkg::*;
#(
    parameter  int IN_W     = DEF_IN_W,
    parameter  int NUM_EDGE = DEF_NUM_EDGE,
    parameter  int NUM_CUBE = DEF_NUM_CUBE,
    localparam int EDGE_W   = (NUM_EDGE > 1) ? $clog2(NUM_EDGE) : 1,
    localparam int ADDR_W   = (NUM_CUBE > 1) ? $clog2(NUM_CUBE) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic                cfg_en,
    input  logic [EDGE_W-1:0]   cfg_edge,
    input  logic [IN_W-1:0]     cfg_care,
    input  logic [IN_W-1:0]     cfg_val,
    input  logic                vox_valid,
    input  logic                vox_last,
    input  logic [IN_W-1:0]     vox_code,
    output logic                vox_ready,
    output logic                busy,
    output logic                cfg_err,
    output logic                mask_valid,
    output logic [NUM_EDGE-1:0] edge_mask
);

    state_t                state;
    logic [ADDR_W-1:0]     idx;
    logic [IN_W-1:0]       code_q;
    logic                  last_q;
    logic                  frame_open;
    logic [NUM_EDGE-1:0]   mask_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  err_q;
    logic                  mv_q;

    logic                  rd_en;
    logic [EDGE_W-1:0]     rd_edge;
    logic [IN_W-1:0]       rd_care;
    logic [IN_W-1:0]       rd_val;
    logic                  match;
    logic [NUM_EDGE-1:0]   hit;
    logic [NUM_EDGE-1:0]   next_mask;
    logic                  scan_end;
    logic                  tbl_we;

    assign tbl_we = cfg_we && (state != ST_SCAN);

    prm_cube_ram #(
        .IN_W     (IN_W),
        .EDGE_W   (EDGE_W),
        .NUM_CUBE (NUM_CUBE),
        .ADDR_W   (ADDR_W)
    ) u_cube_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (tbl_we),
        .waddr   (cfg_addr),
        .wr_en   (cfg_en),
        .wr_edge (cfg_edge),
        .wr_care (cfg_care),
        .wr_val  (cfg_val),
        .raddr   (idx),
        .rd_en   (rd_en),
        .rd_edge (rd_edge),
        .rd_care (rd_care),
        .rd_val  (rd_val)
    );

    assign match = rd_en && (((code_q ^ rd_val) & rd_care) == '0);

    // Edge indices at or beyond NUM_EDGE select no bit and so never flag an edge.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_EDGE; i++) begin
            if (match && (rd_edge == EDGE_W'(i))) begin
                hit[i] = 1'b1;
            end
        end
    end

    assign next_mask = mask_q | hit;
    assign scan_end  = (idx == ADDR_W'(NUM_CUBE - 1)) || (&next_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            code_q     <= '0;
            last_q     <= 1'b0;
            frame_open <= 1'b0;
            mask_q     <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            mv_q       <= 1'b0;
        end else begin
            err_q <= cfg_we && (state == ST_SCAN);
            mv_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (vox_valid) begin
                        code_q     <= vox_code;
                        last_q     <= vox_last;
                        idx        <= '0;
                        frame_open <= 1'b1;
                        if (!frame_open) begin
                            mask_q <= '0;
                        end
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    mask_q <= next_mask;
                    if (scan_end) begin
                        busy_q <= 1'b0;
                        if (last_q) begin
                            mv_q  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            ready_q <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    frame_open <= 1'b0;
                    ready_q    <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign vox_ready  = ready_q;
    assign busy       = busy_q;
    assign cfg_err    = err_q;
    assign mask_valid = mv_q;
    assign edge_mask  = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_prm_edge_mask_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prm_edge_mask_scanner
//  Purpose  : Directed and random frames checked against a table-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prm_edge_mask_scanner;
    import prm_scan_pkg::*;

    localparam int NC = DEF_NUM_CUBE;
    localparam int NE = DEF_NUM_EDGE;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic        cfg_en;
    logic [2:0]  cfg_edge;
    logic [14:0] cfg_care;
    logic [14:0] cfg_val;
    logic        vox_valid;
    logic        vox_last;
    logic [14:0] vox_code;
    logic        vox_ready;
    logic        busy;
    logic        cfg_err;
    logic        mask_valid;
    logic [7:0]  edge_mask;

    int checks   = 0;
    int failures = 0;

    cube_t      tbl [NC];
    logic [7:0] m_mask;
    logic       m_open;

    prm_edge_mask_scanner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_en     (cfg_en),
        .cfg_edge   (cfg_edge),
        .cfg_care   (cfg_care),
        .cfg_val    (cfg_val),
        .vox_valid  (vox_valid),
        .vox_last   (vox_last),
        .vox_code   (vox_code),
        .vox_ready  (vox_ready),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .mask_valid (mask_valid),
        .edge_mask  (edge_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) tbl[i] = '0;
        m_mask = '0;
        m_open = 1'b0;
    endtask

    // Frame semantics: the mask is the OR of the edges of every matching cube;
    // the scan stops at the first cube after which every edge is flagged.
    task automatic model_voxel(input logic [14:0] code, input logic last, output int cyc);
        if (!m_open) m_mask = '0;
        m_open = 1'b1;
        cyc = NC;
        for (int i = 0; i < NC; i++) begin
            if (tbl[i].en && (((code ^ tbl[i].val) & tbl[i].care) == 15'd0) && (int'(tbl[i].edge_idx) < NE))
                m_mask = m_mask | (8'd1 << tbl[i].edge_idx);
            if (m_mask == 8'hFF) begin
                cyc = i + 1;
                break;
            end
        end
        if (last) m_open = 1'b0;
    endtask

    task automatic write_cube(input int addr, input logic en, input int edg,
                              input logic [14:0] care, input logic [14:0] val);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 6'(addr);
        cfg_en   = en;
        cfg_edge = 3'(edg);
        cfg_care = care;
        cfg_val  = val;
        @(negedge clk);
        cfg_we = 1'b0;
        tbl[addr] = '{en: en, edge_idx: 3'(edg), care: care, val: val};
    endtask

    // Sends one voxel; optionally pulses cfg_we mid-scan, drops reset mid-scan,
    // or writes a cube in the same cycle the voxel is accepted.
    task automatic send_voxel(input logic [14:0] code, input logic last,
                              input int inject_at, input int reset_at,
                              input logic with_cfg, input int caddr, input int cedge,
                              input logic [14:0] ccare, input logic [14:0] cval);
        int exp_cyc;
        int count;
        int errs;
        int mv;
        @(negedge clk);
        check("ready_before_accept", vox_ready, 1);
        vox_valid = 1'b1;
        vox_code  = code;
        vox_last  = last;
        if (with_cfg) begin
            cfg_we   = 1'b1;
            cfg_addr = 6'(caddr);
            cfg_en   = 1'b1;
            cfg_edge = 3'(cedge);
            cfg_care = ccare;
            cfg_val  = cval;
            tbl[caddr] = '{en: 1'b1, edge_idx: 3'(cedge), care: ccare, val: cval};
        end
        model_voxel(code, last, exp_cyc);
        @(negedge clk);
        vox_valid = 1'b0;
        cfg_we    = 1'b0;
        count = 0;
        errs  = 0;
        mv    = 0;
        while (busy === 1'b1 && count < 200) begin
            if (count == inject_at) begin
                cfg_we   = 1'b1;
                cfg_addr = 6'd7;
                cfg_en   = 1'b0;
                cfg_edge = 3'd0;
                cfg_care = 15'd0;
                cfg_val  = 15'd0;
            end
            if (count == reset_at) rst_n = 1'b0;
            @(negedge clk);
            cfg_we = 1'b0;
            count++;
            if (cfg_err === 1'b1) errs++;
            if (mask_valid === 1'b1) mv++;
        end
        if (reset_at >= 0) begin
            check("rst_mid_ready", vox_ready, 1);
            check("rst_mid_busy", busy, 0);
            check("rst_mid_mask", edge_mask, 0);
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (mask_valid === 1'b1) mv++;
            end
            check("rst_mid_no_mask_valid", mv, 0);
        end else begin
            check("scan_cycles", count, exp_cyc);
            check("cfg_err_pulses", errs, (inject_at >= 0) ? 1 : 0);
            if (last) begin
                check("done_mask_valid", mask_valid, 1);
                check("done_ready_low", vox_ready, 0);
                check("done_edge_mask", edge_mask, m_mask);
                @(negedge clk);
                check("after_done_mask_valid", mask_valid, 0);
                check("after_done_hold", edge_mask, m_mask);
            end else begin
                check("mid_mask_valid", mask_valid, 0);
                check("mid_edge_mask", edge_mask, m_mask);
            end
        end
    endtask

    task automatic send_plain(input logic [14:0] code, input logic last);
        send_voxel(code, last, -1, -1, 1'b0, 0, 0, 15'd0, 15'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        logic [14:0] code;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_en    = 1'b0;
        cfg_edge  = '0;
        cfg_care  = '0;
        cfg_val   = '0;
        vox_valid = 1'b0;
        vox_last  = 1'b0;
        vox_code  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_vox_ready", vox_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_cfg_err", cfg_err, 0);
        check("reset_mask_valid", mask_valid, 0);
        check("reset_edge_mask", edge_mask, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single exact-match cube: full 64-cycle scan, edge 3 flagged.
        write_cube(0, 1'b1, 3, 15'h7FFF, 15'h1234);
        send_plain(15'h1234, 1'b1);
        check("exact_match_mask", edge_mask, 8'h08);

        // Two-voxel frame, then a fresh frame clears the accumulated mask.
        write_cube(5, 1'b1, 0, 15'h0001, 15'h0001);
        send_plain(15'h0002, 1'b0);
        send_plain(15'h0003, 1'b1);
        check("two_voxel_mask", edge_mask, 8'h01);
        repeat (3) @(negedge clk);
        check("mask_hold_idle", edge_mask, 8'h01);
        send_plain(15'h0000, 1'b1);
        check("new_frame_mask", edge_mask, 8'h00);

        // Wildcard cubes on every edge: early exit after 8 cubes.
        for (int i = 0; i < 8; i++) write_cube(i, 1'b1, i, 15'h0000, 15'h0000);
        send_plain(15'h0000, 1'b1);
        check("early_exit_mask", edge_mask, 8'hFF);

        // Write during scan is dropped; the rescan sees the old table.
        send_voxel(15'h0000, 1'b1, 2, -1, 1'b0, 0, 0, 15'd0, 15'd0);
        send_plain(15'h0000, 1'b1);

        // Reset mid-scan abandons the frame and invalidates the table.
        for (int i = 0; i < 8; i++) write_cube(i, 1'b0, 0, 15'h0000, 15'h0000);
        write_cube(20, 1'b1, 1, 15'h0000, 15'h0000);
        send_voxel(15'h0000, 1'b1, -1, 10, 1'b0, 0, 0, 15'd0, 15'd0);
        send_plain(15'h0000, 1'b1);
        check("post_reset_table_empty", edge_mask, 8'h00);

        // Write together with voxel acceptance is seen by that scan.
        send_voxel(15'h1255, 1'b1, -1, -1, 1'b1, 30, 6, 15'h00FF, 15'h0055);
        check("same_cycle_write_mask", edge_mask, 8'h40);

        // Random tables and frames.
        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 6; w++)
                write_cube(int'($urandom_range(0, NC - 1)), 1'($urandom_range(0, 3) != 0),
                           int'($urandom_range(0, NE - 1)),
                           15'($urandom & $urandom), 15'($urandom));
            nv = int'($urandom_range(1, 3));
            for (int v = 0; v < nv; v++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int pick;
                    pick = int'($urandom_range(0, NC - 1));
                    code = tbl[pick].val ^ (15'($urandom) & ~tbl[pick].care);
                end else begin
                    code = 15'($urandom);
                end
                send_plain(code, 1'(v == nv - 1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
